// File: rtl/mips_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mips_pkg
// Shared encodings for the HI/LO multiply/divide unit: operation codes,
// controller state encoding and the default datapath width.
// Revision: 1.0
// ----------------------------------------------------------------------------
package mips_pkg;

  localparam int DEF_XLEN = 32;

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/hilo_muldiv_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hilo_muldiv_if
// Control-unit / register-file side of the HI/LO multiply/divide unit.
// The master drives operations and MTHI/MTLO, the slave returns HI/LO state.
// Revision: 1.0
// ----------------------------------------------------------------------------
interface hilo_muldiv_if #(
  parameter int XLEN = mips_pkg::DEF_XLEN
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] rs_data;
  logic [XLEN-1:0] rt_data;
  logic            hi_we;
  logic            lo_we;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic            busy;
  logic            done;

  modport master (
    output start, op, rs_data, rt_data, hi_we, lo_we,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, op, rs_data, rt_data, hi_we, lo_we,
    output hi, lo, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/hilo_muldiv.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hilo_muldiv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide share one 2*XLEN accumulator and
// one XLEN operand register; signed operations run on magnitudes and are
// sign-corrected in a final FIX cycle. Fixed latency of XLEN+1 busy cycles.
// Revision: 1.0
// ----------------------------------------------------------------------------
module hilo_muldiv
  import mips_pkg::*;
#(
  parameter int XLEN = DEF_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  hilo_muldiv_if.slave    bus
);

  localparam int CW = $clog2(XLEN);

  // Two's-complement negate at operand width.
  function automatic logic [XLEN-1:0] f_neg(input logic [XLEN-1:0] v);
    return (~v) + XLEN'(1);
  endfunction

  // Two's-complement negate at product width.
  function automatic logic [2*XLEN-1:0] f_neg2(input logic [2*XLEN-1:0] v);
    return (~v) + (2*XLEN)'(1);
  endfunction

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_opnd;
  logic              r_is_div;
  logic              r_neg_main;
  logic              r_neg_rem;
  logic              r_dz;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic              r_busy;
  logic              r_done;

  logic              w_load;
  logic              w_step;
  logic              w_fix;
  logic              w_mt_ok;

  logic              w_op_signed;
  logic              w_op_div;
  logic              w_rs_neg;
  logic              w_rt_neg;
  logic [XLEN-1:0]   w_rs_mag;
  logic [XLEN-1:0]   w_rt_mag;

  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_acc;
  logic [XLEN:0]     w_rem_sh;
  logic              w_ge;
  logic [XLEN-1:0]   w_diff;
  logic [2*XLEN-1:0] w_div_acc;

  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fix_hi;
  logic [XLEN-1:0]   w_fix_lo;

  // Operand decode at launch: signed ops are reduced to magnitudes.
  always_comb begin
    w_op_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    w_op_div    = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    w_rs_neg    = w_op_signed & bus.rs_data[XLEN-1];
    w_rt_neg    = w_op_signed & bus.rt_data[XLEN-1];
    w_rs_mag    = w_rs_neg ? f_neg(bus.rs_data) : bus.rs_data;
    w_rt_mag    = w_rt_neg ? f_neg(bus.rt_data) : bus.rt_data;
  end

  // One iteration of each datapath; the controller picks which one lands.
  always_comb begin
    // Multiply: acc = {partial, multiplier}; add multiplicand on LSB, shift right.
    w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    w_mul_acc = {w_mul_sum, r_acc[XLEN-1:1]};
    // Divide: acc = {remainder, dividend/quotient}; shift left, trial subtract.
    // The shifted remainder can reach XLEN+1 bits, hence the wide compare; when
    // the subtract succeeds the result always fits in XLEN bits.
    w_rem_sh  = r_acc[2*XLEN-1:XLEN-1];
    w_ge      = (w_rem_sh >= {1'b0, r_opnd});
    w_diff    = w_rem_sh[XLEN-1:0] - r_opnd;
    w_div_acc = {(w_ge ? w_diff : w_rem_sh[XLEN-1:0]), r_acc[XLEN-2:0], w_ge};
  end

  // Sign correction and HI/LO selection applied in the FIX cycle.
  always_comb begin
    w_prod   = r_neg_main ? f_neg2(r_acc) : r_acc;
    // Divide by zero yields an all-ones quotient regardless of sign; the
    // remainder path naturally reproduces the original dividend.
    w_quo    = r_dz ? '1 :
               (r_neg_main ? f_neg(r_acc[XLEN-1:0]) : r_acc[XLEN-1:0]);
    w_rem    = r_neg_rem ? f_neg(r_acc[2*XLEN-1:XLEN]) : r_acc[2*XLEN-1:XLEN];
    w_fix_hi = r_is_div ? w_rem : w_prod[2*XLEN-1:XLEN];
    w_fix_lo = r_is_div ? w_quo : w_prod[XLEN-1:0];
  end

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Controller next-state and datapath enables.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_fix       = 1'b0;
    w_mt_ok     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end else begin
          w_mt_ok     = 1'b1;
        end
      end
      S_RUN: begin
        w_step = 1'b1;
        if (r_cnt == '0) begin
          w_state_nxt = S_FIX;
        end
      end
      S_FIX: begin
        w_fix       = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Iteration datapath: operand capture, per-cycle step, step counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_acc      <= '0;
      r_opnd     <= '0;
      r_is_div   <= 1'b0;
      r_neg_main <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_dz       <= 1'b0;
    end else if (w_load) begin
      r_cnt      <= CW'(XLEN-1);
      r_is_div   <= w_op_div;
      r_neg_main <= w_rs_neg ^ w_rt_neg;
      r_neg_rem  <= w_rs_neg;
      r_dz       <= w_op_div && (bus.rt_data == '0);
      if (w_op_div) begin
        r_acc  <= {{XLEN{1'b0}}, w_rs_mag};
        r_opnd <= w_rt_mag;
      end else begin
        r_acc  <= {{XLEN{1'b0}}, w_rt_mag};
        r_opnd <= w_rs_mag;
      end
    end else if (w_step) begin
      r_acc <= r_is_div ? w_div_acc : w_mul_acc;
      r_cnt <= (r_cnt == '0) ? '0 : r_cnt - CW'(1);
    end
  end

  // Architectural HI/LO plus registered busy/done handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_fix;
      if (w_load) begin
        r_busy <= 1'b1;
      end else if (w_fix) begin
        r_busy <= 1'b0;
      end
      if (w_fix) begin
        r_hi <= w_fix_hi;
        r_lo <= w_fix_lo;
      end else if (w_mt_ok) begin
        if (bus.hi_we) r_hi <= bus.rs_data;
        if (bus.lo_we) r_lo <= bus.rs_data;
      end
    end
  end

  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule
`default_nettype wire
